galois_stream_accumulator: RTL and testbench
============================================

Name: galois_stream_accumulator

Overview:
- Reduces a stream of BN254 scalar-field elements to one modular sum, using a single shared three-input modular adder (num1+num2+num3 mod p).
- Each adder firing folds two new elements into the running accumulator, so one adder instance serves the whole vector.
- Sits between the Griffin state/round logic and consumers that need a field-element sum, for example the linear-layer column sums.
- Valid/ready on both sides; one result per in_last-terminated stream.

Parameters:
- N_BITS, 254, field element width.
- PRIME_MODULUS, 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001, field modulus p (N_BITS wide).
- CNT_W, 16, width of the element counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_data  in  N_BITS  element; must be canonical (< p); non-canonical input is out of contract.
- in_valid  in  1  in_data/in_last are valid.
- in_last  in  1  marks the final element of the stream.
- in_ready  out  1  block accepts a beat this cycle.
- out_sum  out  N_BITS  modular sum of the stream, canonical.
- out_count  out  CNT_W  number of elements accepted; saturating.
- out_valid  out  1  out_sum/out_count valid.
- out_ready  in  1  consumer accepts the result.

Behaviour:
- Beat accepted when in_valid && in_ready. Result transferred when out_valid && out_ready.
- Reset (rst=1 at an edge, any state, mid-stream included):
  - state=IDLE; acc=0; pend=0; pend_v=0; cnt=0.
  - out_valid=0; out_sum=0; out_count=0; in_ready=1 the following cycle.
  - A partial stream is discarded.
- States:
  - IDLE: acc=0, no element held.
  - ACCUM: at least one element accepted, in_last not yet seen.
  - DONE: result held.
- in_ready = (state != DONE). No same-cycle bypass from DONE to IDLE.
- There is exactly one adder instance, with operands muxed as follows.
- Accepted beat, IDLE or ACCUM, cnt increments (saturating at 2^CNT_W-1):
  - pend_v=0, in_last=0: pend<=in_data; pend_v<=1; state->ACCUM.
  - pend_v=1, any in_last: acc<=add3(acc, pend, in_data); pend_v<=0.
  - pend_v=0, in_last=1: acc<=add3(acc, in_data, 0).
  - If in_last=1: state->DONE, out_valid=1 on the next cycle (latency 1 from the last beat).
- Adder contract: all three operands < p, so the raw sum < 3p. The adder returns a canonical result.
- out_sum = acc and out_count = cnt whenever out_valid=1. Both are held stable while out_valid=1 && out_ready=0.
- DONE with out_ready=1: out_valid deasserts next cycle; acc, cnt, pend_v cleared; state->IDLE; in_ready=1 next cycle.
- in_valid=0 in any state: no state change; pend and acc are held.
- Single-element stream (in_last on the first beat) is legal: sum equals the element, count=1.
- Empty stream is not representable; out_valid never asserts without an accepted in_last beat.
- out_ready ignored while out_valid=0.
- in_data, in_last ignored when in_valid=0 or in_ready=0.
- Throughput: one element per cycle while streaming; one idle input cycle per stream (the DONE handoff).

Test Plan:
- Reset, then single beat in_data=5, in_last=1, out_ready=1 -> next cycle out_valid=1, out_sum=5, out_count=1; following cycle out_valid=0, in_ready=1.
- Stream 1, 2, 3 (in_last on 3), back-to-back -> out_sum=6, out_count=3, out_valid exactly 1 cycle after the third beat.
- Stream p-1, p-1, p-1, p-1 (last on the fourth) -> out_sum=p-4 (…f0000001 minus 4 = …effffffd), out_count=4. Repeat with p-1, p-1, p-1 (odd length) -> out_sum=p-3.
- Backpressure: stream 10, 20 (last); hold out_ready=0 for 5 cycles with in_valid=1, in_data=99 -> in_ready=0 throughout, out_sum=30 stable. Then out_ready=1 -> 99 accepted only once back in IDLE; next result is 99 if in_last=1.
- Reset mid-stream: accept 7, 8, assert rst one cycle, then stream 4 (last) -> out_sum=4, out_count=1; no out_valid pulse from the aborted stream.
- CNT_W=2: stream five elements of 1 with gaps (in_valid toggling) -> out_sum=5, out_count=3 (saturated).

Source files
------------

// File: rtl/galois_stream_accumulator.sv
// Folds a valid/ready stream of BN254 scalar-field elements into one canonical
// modular sum, two elements per firing of a single shared three-input adder.
module galois_stream_accumulator #(
    parameter int unsigned        N_BITS        = 254,
    parameter logic [N_BITS-1:0]  PRIME_MODULUS = 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001,
    parameter int unsigned        CNT_W         = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_BITS-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [N_BITS-1:0] out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_valid,
    input  logic              out_ready
);

    // Two guard bits: three canonical operands sum to less than 3p.
    localparam int unsigned SUM_W = N_BITS + 2;
    localparam logic [SUM_W-1:0] P1 = SUM_W'(PRIME_MODULUS);
    localparam logic [SUM_W-1:0] P2 = {P1[SUM_W-2:0], 1'b0};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]        state, state_nxt;
    logic [N_BITS-1:0] acc, acc_nxt;
    logic [N_BITS-1:0] pend, pend_nxt;
    logic              pend_v, pend_v_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              out_valid_nxt;
    logic              in_ready_nxt;
    logic              accept;

    logic [N_BITS-1:0] add_a, add_b, add_c;
    logic [SUM_W-1:0]  add_raw;
    logic [N_BITS-1:0] add_sum;

    // Shared adder: a held element pairs with the incoming one; otherwise the
    // incoming element is added alone with a zero third operand.
    always_comb begin
        add_a   = acc;
        add_b   = pend_v ? pend : in_data;
        add_c   = pend_v ? in_data : '0;
        add_raw = SUM_W'(add_a) + SUM_W'(add_b) + SUM_W'(add_c);
        if (add_raw >= P2) begin
            add_sum = N_BITS'(add_raw - P2);
        end else if (add_raw >= P1) begin
            add_sum = N_BITS'(add_raw - P1);
        end else begin
            add_sum = N_BITS'(add_raw);
        end
    end

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            acc       <= '0;
            pend      <= '0;
            pend_v    <= 1'b0;
            cnt       <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            state     <= state_nxt;
            acc       <= acc_nxt;
            pend      <= pend_nxt;
            pend_v    <= pend_v_nxt;
            cnt       <= cnt_nxt;
            out_valid <= out_valid_nxt;
            in_ready  <= in_ready_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        acc_nxt    = acc;
        pend_nxt   = pend;
        pend_v_nxt = pend_v;
        cnt_nxt    = cnt;
        case (state)
            S_IDLE, S_ACCUM: begin
                if (accept) begin
                    cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
                    if (!pend_v && !in_last) begin
                        pend_nxt   = in_data;
                        pend_v_nxt = 1'b1;
                        state_nxt  = S_ACCUM;
                    end else begin
                        acc_nxt    = add_sum;
                        pend_v_nxt = 1'b0;
                    end
                    if (in_last) begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    acc_nxt    = '0;
                    cnt_nxt    = '0;
                    pend_v_nxt = 1'b0;
                    state_nxt  = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        out_valid_nxt = (state_nxt == S_DONE);
        in_ready_nxt  = (state_nxt != S_DONE);
    end

    // Result registers double as the accumulator and counter; they only
    // change outside DONE, so they are stable while a result is pending.
    assign out_sum   = acc;
    assign out_count = cnt;

endmodule

// File: tb/tb_galois_stream_accumulator.sv
// Directed bench for galois_stream_accumulator; a second instance with a
// 2-bit counter shares the stimulus to exercise count saturation.
module tb_galois_stream_accumulator;

    localparam int unsigned N_BITS = 254;
    localparam logic [N_BITS-1:0] P = 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;

    logic              clk;
    logic              rst;
    logic [N_BITS-1:0] in_data;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic [N_BITS-1:0] out_sum;
    logic [15:0]       out_count;
    logic              out_valid;
    logic              out_ready;

    logic              in_ready2;
    logic [N_BITS-1:0] out_sum2;
    logic [1:0]        out_count2;
    logic              out_valid2;

    int n_checks;
    int n_pass;

    galois_stream_accumulator #(.N_BITS(N_BITS), .PRIME_MODULUS(P), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .out_sum(out_sum), .out_count(out_count),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    galois_stream_accumulator #(.N_BITS(N_BITS), .PRIME_MODULUS(P), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready2), .out_sum(out_sum2), .out_count(out_count2),
        .out_valid(out_valid2), .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [N_BITS-1:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        rst       = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst_out_valid", 256'(out_valid), 256'd0);
        check("rst_in_ready",  256'(in_ready),  256'd1);
        check("rst_out_sum",   256'(out_sum),   256'd0);
        check("rst_out_count", 256'(out_count), 256'd0);
        rst = 1'b0;

        // Single-element stream
        out_ready = 1'b1;
        beat(254'd5, 1'b1);
        check("single_valid", 256'(out_valid), 256'd1);
        check("single_sum",   256'(out_sum),   256'd5);
        check("single_count", 256'(out_count), 256'd1);
        check("single_ready_low", 256'(in_ready), 256'd0);
        tick();
        check("single_valid_drop", 256'(out_valid), 256'd0);
        check("single_ready_back", 256'(in_ready),  256'd1);

        // Back-to-back 1,2,3
        in_valid = 1'b1; in_data = 254'd1; in_last = 1'b0; tick();
        in_data = 254'd2; tick();
        check("s123_no_early_valid", 256'(out_valid), 256'd0);
        beat(254'd3, 1'b1);
        check("s123_valid", 256'(out_valid), 256'd1);
        check("s123_sum",   256'(out_sum),   256'd6);
        check("s123_count", 256'(out_count), 256'd3);
        tick();
        check("s123_valid_drop", 256'(out_valid), 256'd0);

        // Wraparound: four and three copies of p-1
        in_valid = 1'b1; in_data = P - 254'd1; in_last = 1'b0;
        tick(); tick(); tick();
        beat(P - 254'd1, 1'b1);
        check("pm1x4_sum",   256'(out_sum),   256'(P - 254'd4));
        check("pm1x4_count", 256'(out_count), 256'd4);
        tick();
        in_valid = 1'b1; in_data = P - 254'd1; in_last = 1'b0;
        tick(); tick();
        beat(P - 254'd1, 1'b1);
        check("pm1x3_sum",   256'(out_sum),   256'(P - 254'd3));
        check("pm1x3_count", 256'(out_count), 256'd3);
        tick();

        // Backpressure holds the result and blocks input
        out_ready = 1'b0;
        beat(254'd10, 1'b0);
        beat(254'd20, 1'b1);
        in_valid = 1'b1; in_data = 254'd99; in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_in_ready",  256'(in_ready),  256'd0);
            check("bp_out_valid", 256'(out_valid), 256'd1);
            check("bp_out_sum",   256'(out_sum),   256'd30);
            tick();
        end
        check("bp_count", 256'(out_count), 256'd2);
        out_ready = 1'b1;
        tick();
        check("bp_release_valid", 256'(out_valid), 256'd0);
        check("bp_release_ready", 256'(in_ready),  256'd1);
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        check("bp_next_valid", 256'(out_valid), 256'd1);
        check("bp_next_sum",   256'(out_sum),   256'd99);
        check("bp_next_count", 256'(out_count), 256'd1);
        tick();

        // Reset mid-stream discards the partial stream
        beat(254'd7, 1'b0);
        beat(254'd8, 1'b0);
        check("abort_no_valid", 256'(out_valid), 256'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_valid", 256'(out_valid), 256'd0);
        check("abort_sum",   256'(out_sum),   256'd0);
        check("abort_count", 256'(out_count), 256'd0);
        beat(254'd4, 1'b1);
        check("abort_next_valid", 256'(out_valid), 256'd1);
        check("abort_next_sum",   256'(out_sum),   256'd4);
        check("abort_next_count", 256'(out_count), 256'd1);
        tick();

        // Five ones with gaps; the 2-bit counter saturates at 3
        for (int i = 0; i < 5; i++) begin
            beat(254'd1, (i == 4));
            if (i < 4) begin
                check("gap_no_valid", 256'(out_valid), 256'd0);
                tick();
            end
        end
        check("sat_valid",   256'(out_valid2), 256'd1);
        check("sat_sum",     256'(out_sum2),   256'd5);
        check("sat_count",   256'(out_count2), 256'd3);
        check("wide_count",  256'(out_count),  256'd5);
        tick();
        check("sat_valid_drop", 256'(out_valid2), 256'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
